// File: rtl/add_seq_pkg.sv
// rtl/add_seq_pkg.sv - shared word width, FSM encoding and width helpers for the sequenced adder
package add_seq_pkg;

    localparam int W = 32;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        RUN  = 2'd1,
        RESP = 2'd2
    } state_t;

    function automatic int cnt_width(input int words);
        return $clog2(words + 1);
    endfunction

    function automatic int idx_width(input int words);
        return (words < 2) ? 1 : $clog2(words);
    endfunction

endpackage

// File: rtl/add_seq_ctrl_if.sv
// rtl/add_seq_ctrl_if.sv - request/response bus of add_seq_ctrl (op_sub_i present with ADD_SEQ_SUB_EN)
interface add_seq_ctrl_if #(
    parameter int WORDS = 4
);
    import add_seq_pkg::*;

    localparam int N  = W * WORDS;
    localparam int CW = cnt_width(WORDS);

    logic          req_valid_i;
    logic          req_ready_o;
    logic [N-1:0]  a_i;
    logic [N-1:0]  b_i;
    logic          cin_i;
`ifdef ADD_SEQ_SUB_EN
    logic          op_sub_i;
`endif
    logic          rsp_valid_o;
    logic          rsp_ready_i;
    logic [N-1:0]  sum_o;
    logic          cout_o;
    logic [CW-1:0] skip_cnt_o;

    modport slave (
        input  req_valid_i, a_i, b_i, cin_i,
`ifdef ADD_SEQ_SUB_EN
        input  op_sub_i,
`endif
        input  rsp_ready_i,
        output req_ready_o, rsp_valid_o, sum_o, cout_o, skip_cnt_o
    );

    modport master (
        output req_valid_i, a_i, b_i, cin_i,
`ifdef ADD_SEQ_SUB_EN
        output op_sub_i,
`endif
        output rsp_ready_i,
        input  req_ready_o, rsp_valid_o, sum_o, cout_o, skip_cnt_o
    );

endinterface

// File: rtl/add_word.sv
// rtl/add_word.sv - combinational 32-bit word adder with carry and all-ones propagate flag
module add_word
    import add_seq_pkg::*;
(
    input  logic [W-1:0] a_i,
    input  logic [W-1:0] b_i,
    input  logic         cin_i,
    output logic [W-1:0] sum_o,
    output logic         cout_o,
    output logic         prop_all_o
);

    assign {cout_o, sum_o} = {1'b0, a_i} + {1'b0, b_i} + {{W{1'b0}}, cin_i};
    assign prop_all_o      = &(a_i ^ b_i);

endmodule

// File: rtl/add_seq_ctrl.sv
// rtl/add_seq_ctrl.sv - multi-cycle wide adder: one 32-bit word per cycle, carry chained LSW->MSW
// Optional macro ADD_SEQ_SUB_EN adds op_sub_i (A-B via inverted B and carry-in of 1).
module add_seq_ctrl
    import add_seq_pkg::*;
#(
    parameter int WORDS = 4
) (
    input  logic         clk,
    input  logic         rst_n,
    add_seq_ctrl_if.slave bus
);

    localparam int IW = idx_width(WORDS);
    localparam int CW = cnt_width(WORDS);

    state_t                   state_q, state_d;
    logic [WORDS-1:0][W-1:0]  a_q, a_d;
    logic [WORDS-1:0][W-1:0]  b_q, b_d;
    logic [WORDS-1:0][W-1:0]  sum_q, sum_d;
    logic                     carry_q, carry_d;
    logic [IW-1:0]            idx_q, idx_d;
    logic [CW-1:0]            skip_q, skip_d;
    logic                     req_ready_q, req_ready_d;
    logic                     rsp_valid_q, rsp_valid_d;

    logic [W-1:0]             s_word;
    logic                     c_word;
    logic                     p_word;

    add_word u_add_word (
        .a_i        (a_q[idx_q]),
        .b_i        (b_q[idx_q]),
        .cin_i      (carry_q),
        .sum_o      (s_word),
        .cout_o     (c_word),
        .prop_all_o (p_word)
    );

    always_comb begin
        state_d = state_q;
        a_d     = a_q;
        b_d     = b_q;
        sum_d   = sum_q;
        carry_d = carry_q;
        idx_d   = idx_q;
        skip_d  = skip_q;
        case (state_q)
            IDLE: begin
                if (bus.req_valid_i && req_ready_q) begin
                    a_d    = bus.a_i;
                    // Subtraction stores ~B so the word adder and skip test need no mode awareness.
`ifdef ADD_SEQ_SUB_EN
                    b_d     = bus.op_sub_i ? ~bus.b_i : bus.b_i;
                    carry_d = bus.op_sub_i ? 1'b1 : bus.cin_i;
`else
                    b_d     = bus.b_i;
                    carry_d = bus.cin_i;
`endif
                    sum_d   = '0;
                    skip_d  = '0;
                    idx_d   = '0;
                    state_d = RUN;
                end
            end
            RUN: begin
                sum_d[idx_q] = s_word;
                carry_d      = c_word;
                skip_d       = skip_q + CW'(p_word);
                if (idx_q == IW'(WORDS - 1)) begin
                    state_d = RESP;
                end else begin
                    idx_d = idx_q + IW'(1);
                end
            end
            RESP: begin
                if (bus.rsp_ready_i) begin
                    state_d = IDLE;
                end
            end
            default: state_d = IDLE;
        endcase
        req_ready_d = (state_d == IDLE);
        rsp_valid_d = (state_d == RESP);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q     <= IDLE;
            a_q         <= '0;
            b_q         <= '0;
            sum_q       <= '0;
            carry_q     <= 1'b0;
            idx_q       <= '0;
            skip_q      <= '0;
            req_ready_q <= 1'b1;
            rsp_valid_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            a_q         <= a_d;
            b_q         <= b_d;
            sum_q       <= sum_d;
            carry_q     <= carry_d;
            idx_q       <= idx_d;
            skip_q      <= skip_d;
            req_ready_q <= req_ready_d;
            rsp_valid_q <= rsp_valid_d;
        end
    end

    assign bus.req_ready_o = req_ready_q;
    assign bus.rsp_valid_o = rsp_valid_q;
    assign bus.sum_o       = sum_q;
    assign bus.cout_o      = carry_q;
    assign bus.skip_cnt_o  = skip_q;

endmodule

// File: tb/tb_add_seq_ctrl.sv
// tb/tb_add_seq_ctrl.sv - scoreboard bench for add_seq_ctrl (WORDS=4), covers ADD_SEQ_SUB_EN when defined
module tb_add_seq_ctrl;

    localparam int WORDS = 4;
    localparam int N     = 32 * WORDS;

    typedef struct {
        logic [N-1:0] sum;
        logic         cout;
        logic [2:0]   skip;
    } exp_t;

    logic clk;
    logic rst_n;
    int   cyc;
    int   n_pass;
    int   n_total;
    int   bp_mode;

    exp_t exp_q[$];
    int   acc_q[$];

    logic         held;
    logic         was_valid;
    logic         hs_prev;
    logic [N-1:0] held_sum;
    logic         held_cout;
    logic [2:0]   held_skip;

    add_seq_ctrl_if #(.WORDS(WORDS)) bus ();

    add_seq_ctrl #(.WORDS(WORDS)) dut (
        .clk   (clk),
        .rst_n (rst_n),
        .bus   (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    task automatic check(input string nm, input logic [N-1:0] got, input logic [N-1:0] exp);
        n_total++;
        if (got === exp) n_pass++;
        else $display("FAIL %s: got %h expected %h", nm, got, exp);
    endtask

    // Whole-operand reference: one wide addition, skip count by examining each word of A^B'.
    function automatic exp_t model(input logic [N-1:0] a, input logic [N-1:0] b,
                                   input logic cin, input logic sub);
        exp_t         e;
        logic [N:0]   r;
        logic [N-1:0] bb;
        logic [N-1:0] p;
        int           cnt;
        bb  = sub ? ~b : b;
        r   = {1'b0, a} + {1'b0, bb} + (sub ? (N+1)'(1) : (N+1)'(cin));
        p   = a ^ bb;
        cnt = 0;
        for (int k = 0; k < WORDS; k++)
            if (p[k*32 +: 32] == 32'hFFFF_FFFF) cnt++;
        e.sum  = r[N-1:0];
        e.cout = r[N];
        e.skip = 3'(cnt);
        return e;
    endfunction

    task automatic send(input logic [N-1:0] a, input logic [N-1:0] b, input logic cin,
                        input logic sub, input exp_t e);
        int waited;
        waited = 0;
        @(negedge clk);
        while (!bus.req_ready_o && waited < 100) begin
            @(negedge clk);
            waited++;
        end
        if (!bus.req_ready_o) begin
            $display("FAIL req_ready_timeout: got 0 expected 1");
            n_total++;
            return;
        end
        bus.req_valid_i = 1'b1;
        bus.a_i         = a;
        bus.b_i         = b;
        bus.cin_i       = cin;
`ifdef ADD_SEQ_SUB_EN
        bus.op_sub_i    = sub;
`endif
        exp_q.push_back(e);
        acc_q.push_back(cyc + 1);
        @(negedge clk);
        bus.req_valid_i = 1'b0;
        bus.a_i         = {$urandom, $urandom, $urandom, $urandom};
        bus.b_i         = {$urandom, $urandom, $urandom, $urandom};
        bus.cin_i       = 1'($urandom);
`ifdef ADD_SEQ_SUB_EN
        bus.op_sub_i    = 1'($urandom);
`endif
    endtask

    task automatic send_model(input logic [N-1:0] a, input logic [N-1:0] b,
                              input logic cin, input logic sub);
        send(a, b, cin, sub, model(a, b, cin, sub));
    endtask

    task automatic drain();
        for (int i = 0; i < 500 && exp_q.size() != 0; i++) @(negedge clk);
        check("drain_empty", N'(exp_q.size()), '0);
    endtask

    // Monitor: owns rsp_ready_i, checks latency, hold stability and every completed response.
    always @(negedge clk) begin
        if (!rst_n) begin
            held      = 1'b0;
            was_valid = 1'b0;
            hs_prev   = 1'b0;
            bus.rsp_ready_i = 1'b0;
        end else begin
            if (hs_prev) begin
                check("post_hs_req_ready", N'(bus.req_ready_o), N'(1));
                check("post_hs_rsp_valid", N'(bus.rsp_valid_o), '0);
                hs_prev = 1'b0;
            end
            if (bus.rsp_valid_o && !was_valid) begin
                if (acc_q.size() == 0) check("latency_no_accept", N'(1), '0);
                else check("latency", N'(cyc - acc_q.pop_front()), N'(WORDS));
            end
            if (bus.rsp_valid_o && held) begin
                check("hold_sum", bus.sum_o, held_sum);
                check("hold_cout", N'(bus.cout_o), N'(held_cout));
                check("hold_skip", N'(bus.skip_cnt_o), N'(held_skip));
                check("hold_req_ready", N'(bus.req_ready_o), '0);
            end
            case (bp_mode)
                1:       bus.rsp_ready_i = 1'b0;
                2:       bus.rsp_ready_i = 1'b1;
                default: bus.rsp_ready_i = 1'($urandom_range(0, 1));
            endcase
            if (bus.rsp_valid_o && bus.rsp_ready_i) begin
                if (exp_q.size() == 0) begin
                    check("unexpected_rsp", N'(1), '0);
                end else begin
                    exp_t e;
                    e = exp_q.pop_front();
                    check("sum", bus.sum_o, e.sum);
                    check("cout", N'(bus.cout_o), N'(e.cout));
                    check("skip_cnt", N'(bus.skip_cnt_o), N'(e.skip));
                end
                hs_prev = 1'b1;
                held    = 1'b0;
            end else if (bus.rsp_valid_o) begin
                held      = 1'b1;
                held_sum  = bus.sum_o;
                held_cout = bus.cout_o;
                held_skip = bus.skip_cnt_o;
            end
            was_valid = bus.rsp_valid_o;
        end
    end

    initial begin
        exp_t e;
        logic [N-1:0] ra, rb;
        int waited;
        n_pass  = 0;
        n_total = 0;
        bp_mode = 2;
        rst_n   = 1'b0;
        bus.req_valid_i = 1'b0;
        bus.a_i   = '0;
        bus.b_i   = '0;
        bus.cin_i = 1'b0;
`ifdef ADD_SEQ_SUB_EN
        bus.op_sub_i = 1'b0;
`endif
        repeat (3) @(negedge clk);
        rst_n = 1'b1;
        @(negedge clk);
        check("rst_req_ready", N'(bus.req_ready_o), N'(1));
        check("rst_rsp_valid", N'(bus.rsp_valid_o), '0);
        check("rst_sum", bus.sum_o, '0);
        check("rst_cout", N'(bus.cout_o), '0);
        check("rst_skip", N'(bus.skip_cnt_o), '0);

        e = '{sum: N'(2), cout: 1'b0, skip: 3'd0};
        send(N'(1), N'(1), 1'b0, 1'b0, e);
        e = '{sum: '0, cout: 1'b1, skip: 3'd4};
        send({N{1'b1}}, '0, 1'b1, 1'b0, e);
        e = '{sum: N'(64'h1_0000_0000), cout: 1'b0, skip: 3'd0};
        send(N'(64'hFFFF_FFFF), N'(1), 1'b0, 1'b0, e);
        drain();

        // Backpressure: response must hold still for 5 cycles, then release.
        bp_mode = 1;
        send_model({$urandom, $urandom, $urandom, $urandom}, {$urandom, $urandom, $urandom, $urandom},
                   1'b1, 1'b0);
        waited = 0;
        while (!bus.rsp_valid_o && waited < 50) begin
            @(negedge clk);
            waited++;
        end
        check("hold_rsp_seen", N'(bus.rsp_valid_o), N'(1));
        repeat (5) @(negedge clk);
        @(posedge clk);
        #1 bp_mode = 2;
        drain();

        // Reset in the middle of RUN aborts the operation.
        send(N'(11), N'(22), 1'b0, 1'b0, '{sum: N'(33), cout: 1'b0, skip: 3'd0});
        @(posedge clk);
        @(posedge clk);
        #1 rst_n = 1'b0;
        #1;
        check("abort_rsp_valid", N'(bus.rsp_valid_o), '0);
        check("abort_sum", bus.sum_o, '0);
        check("abort_skip", N'(bus.skip_cnt_o), '0);
        exp_q.delete();
        acc_q.delete();
        @(posedge clk);
        #1 rst_n = 1'b1;
        @(negedge clk);
        check("after_rst_req_ready", N'(bus.req_ready_o), N'(1));
        check("after_rst_sum", bus.sum_o, '0);
        send(N'(3), N'(4), 1'b0, 1'b0, '{sum: N'(7), cout: 1'b0, skip: 3'd0});
        drain();

`ifdef ADD_SEQ_SUB_EN
        send(N'(5), N'(7), 1'b1, 1'b1, '{sum: {{(N-1){1'b1}}, 1'b0}, cout: 1'b0, skip: 3'd3});
        send(N'(7), N'(5), 1'b0, 1'b1, '{sum: N'(2), cout: 1'b1, skip: 3'd3});
        drain();
`endif

        bp_mode = 0;
        for (int i = 0; i < 40; i++) begin
            logic sub;
`ifdef ADD_SEQ_SUB_EN
            sub = 1'($urandom);
`else
            sub = 1'b0;
`endif
            for (int k = 0; k < WORDS; k++) begin
                ra[k*32 +: 32] = $urandom;
                if ($urandom_range(0, 2) == 0)
                    rb[k*32 +: 32] = sub ? ra[k*32 +: 32] : ~ra[k*32 +: 32];
                else
                    rb[k*32 +: 32] = $urandom;
            end
            send_model(ra, rb, 1'($urandom), sub);
            repeat ($urandom_range(0, 2)) @(negedge clk);
        end
        drain();

        $display("%0d/%0d checks passed", n_pass, n_total);
        $finish;
    end

endmodule
